exec_time_monitor: RTL

//  Multi-channel execution-time monitor: the synthesizable, parametrised successor of the NM-Carus

---
 rtl/exec_time_monitor.sv | 125 ++++++++++++
 1 files changed

// File: rtl/exec_time_monitor.sv
// Multi-channel start->done cycle timer with timeout watchdog and saturation flag; status 1 cycle after the input rise.
// No backpressure: inputs are sampled every cycle and results hold until the next start or clear.
module exec_time_monitor #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32,
   parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NUM_CH-1:0] start_i,
   input  logic [NUM_CH-1:0] done_i,
   input  logic              clear_i,
   input  logic [CNT_W-1:0]  timeout_i,
   input  logic [SEL_W-1:0]  sel_i,
   output logic [CNT_W-1:0]  cycles_o,
   output logic [NUM_CH-1:0] busy_o,
   output logic [NUM_CH-1:0] valid_o,
   output logic [NUM_CH-1:0] timeout_o,
   output logic [NUM_CH-1:0] sat_o,
   output logic              active_o
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TMO} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            r_state     [NUM_CH];
   state_t            w_state_nxt [NUM_CH];
   logic [CNT_W-1:0]  r_cnt       [NUM_CH];
   logic [CNT_W-1:0]  w_cnt_nxt   [NUM_CH];
   logic [CNT_W-1:0]  w_inc       [NUM_CH];
   logic [NUM_CH-1:0] r_sat;
   logic [NUM_CH-1:0] w_sat_nxt;
   logic [NUM_CH-1:0] r_start_q;
   logic [NUM_CH-1:0] r_done_q;
   logic [NUM_CH-1:0] w_start_rise;
   logic [NUM_CH-1:0] w_done_rise;
   logic [CNT_W-1:0]  w_cycles;

   // Edge registers keep tracking the inputs through reset and clear, so a level
   // held high across either is never seen as a fresh rise.
   always_ff @(posedge clk_i) begin
      r_start_q <= start_i;
      r_done_q  <= done_i;
   end

   assign w_start_rise = start_i & ~r_start_q;
   assign w_done_rise  = done_i  & ~r_done_q;

   always_comb begin
      w_sat_nxt = r_sat;
      for (int c = 0; c < NUM_CH; c++) begin
         w_inc[c]       = r_cnt[c] + CNT_ONE;
         w_state_nxt[c] = r_state[c];
         w_cnt_nxt[c]   = r_cnt[c];
         if (clear_i) begin
            w_state_nxt[c] = S_IDLE;
            w_cnt_nxt[c]   = '0;
            w_sat_nxt[c]   = 1'b0;
         end else if (r_state[c] == S_RUN) begin
            // The done edge still counts its own cycle, so a gap of N edges reports N.
            if (r_cnt[c] == CNT_MAX) begin
               w_sat_nxt[c] = 1'b1;
               if (w_done_rise[c]) begin
                  w_state_nxt[c] = S_DONE;
               end
            end else begin
               w_cnt_nxt[c] = w_inc[c];
               if (w_done_rise[c]) begin
                  w_state_nxt[c] = S_DONE;
               end else if ((timeout_i != '0) && (w_inc[c] == timeout_i)) begin
                  w_state_nxt[c] = S_TMO;
               end
            end
         end else if (w_start_rise[c]) begin
            w_state_nxt[c] = S_RUN;
            w_cnt_nxt[c]   = '0;
            w_sat_nxt[c]   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sat <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            r_state[c] <= S_IDLE;
            r_cnt[c]   <= '0;
         end
      end else begin
         r_sat <= w_sat_nxt;
         for (int c = 0; c < NUM_CH; c++) begin
            r_state[c] <= w_state_nxt[c];
            r_cnt[c]   <= w_cnt_nxt[c];
         end
      end
   end

   always_comb begin
      busy_o    = '0;
      valid_o   = '0;
      timeout_o = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         busy_o[c]    = (r_state[c] == S_RUN);
         valid_o[c]   = (r_state[c] == S_DONE);
         timeout_o[c] = (r_state[c] == S_TMO);
      end
   end

   // Out-of-range selects match no channel and read as zero.
   always_comb begin
      w_cycles = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (sel_i == c[SEL_W-1:0]) begin
            w_cycles = r_cnt[c];
         end
      end
   end

   assign cycles_o = w_cycles;
   assign sat_o    = r_sat;
   assign active_o = |busy_o;

endmodule
